// File: rtl/half_word_loader.sv
// Immediate-insertion unit: drops CHUNK-wide immediates into a WIDTH-wide value,
// extends them, or assembles a full-width constant from successive SEQ beats.
module half_word_loader #(
    parameter int WIDTH = 10,
    parameter int CHUNK = 5,
    localparam int NCH = WIDTH / CHUNK,
    localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [SW-1:0]    sel,
    input  logic [CHUNK-1:0] imm,
    input  logic [WIDTH-1:0] rs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             seq_abort
);

    // Handshake: a request is taken when in_valid && in_ready; a result is taken
    // when out_valid && out_ready. in_ready is high whenever the output register
    // is empty or is being drained this cycle, so both may happen together.

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } seq_state_t;

    localparam logic [2:0] MODE_INSERT = 3'd0;
    localparam logic [2:0] MODE_ZEXT   = 3'd1;
    localparam logic [2:0] MODE_SEXT   = 3'd2;
    localparam logic [2:0] MODE_SEQ    = 3'd3;

    seq_state_t       state, state_next;
    logic [SW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0] acc_shift;
    logic [WIDTH-1:0] ins_result;
    logic [WIDTH-1:0] op_result;
    logic [WIDTH-1:0] load_data;
    logic             load;
    logic             abort_next;
    logic             acc_fire;
    logic             seq_last;

    assign in_ready  = !out_valid || out_ready;
    assign acc_fire  = in_valid && in_ready;
    assign acc_shift = (acc << CHUNK) | WIDTH'(imm);
    assign seq_last  = (cnt == SW'(NCH - 1));

    // Out-of-range sel matches no chunk, leaving rs untouched.
    always_comb begin
        ins_result = rs;
        for (int i = 0; i < NCH; i++) begin
            if (sel == SW'(i)) begin
                ins_result[i*CHUNK +: CHUNK] = imm;
            end
        end
    end

    always_comb begin
        case (mode)
            MODE_INSERT: op_result = ins_result;
            MODE_ZEXT:   op_result = WIDTH'(imm);
            MODE_SEXT:   op_result = WIDTH'($signed(imm));
            default:     op_result = rs;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_next   = acc;
        load       = 1'b0;
        load_data  = op_result;
        abort_next = 1'b0;
        if (acc_fire) begin
            if (mode == MODE_SEQ) begin
                if (seq_last) begin
                    load       = 1'b1;
                    load_data  = acc_shift;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    acc_next   = acc_shift;
                    cnt_next   = cnt + SW'(1);
                    state_next = COLLECT;
                end
            end else begin
                load = 1'b1;
                // A foreign request in the middle of a sequence discards it.
                if (state == COLLECT) begin
                    abort_next = 1'b1;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            seq_abort <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            acc       <= acc_next;
            seq_abort <= abort_next;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_half_word_loader.sv
// Bench for half_word_loader: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_half_word_loader;

    localparam int W   = 10;
    localparam int C   = 5;
    localparam int NCH = W / C;
    localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    mode = 3'd0;
    logic [SW-1:0] sel = '0;
    logic [C-1:0]  imm = '0;
    logic [W-1:0]  rs = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          seq_abort;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state: pending result, SEQ beats collected so far, results not yet taken.
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic         m_abort = 1'b0;
    logic [C-1:0] beats[$];
    logic [W-1:0] exp_q[$];

    half_word_loader #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .imm       (imm),
        .rs        (rs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .seq_abort (seq_abort)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] m, input int s,
                                            input longint im, input longint r);
        longint mask;
        longint res;
        case (m)
            3'd0: begin
                if (s < NCH) begin
                    mask = ((longint'(1) << C) - 1) << (s * C);
                    res  = (r & ~mask) | (im << (s * C));
                end else begin
                    res = r;
                end
            end
            3'd1: res = im;
            3'd2: res = (im >= (longint'(1) << (C - 1))) ?
                        im + (longint'(1) << W) - (longint'(1) << C) : im;
            default: res = r;
        endcase
        return W'(res);
    endfunction

    function automatic logic [W-1:0] assemble();
        longint v = 0;
        foreach (beats[k]) v = (v << C) + longint'(beats[k]);
        return W'(v);
    endfunction

    // ---------------- behavioural model ----------------
    always @(posedge clk) begin
        logic         fire;
        logic         ld;
        logic [W-1:0] r;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_abort = 1'b0;
            beats.delete();
            exp_q.delete();
        end else begin
            fire = in_valid && (!m_valid || out_ready);
            ld   = 1'b0;
            r    = '0;
            m_abort = 1'b0;
            if (fire) begin
                if (mode == 3'd3) begin
                    beats.push_back(imm);
                    if (beats.size() == NCH) begin
                        r  = assemble();
                        ld = 1'b1;
                        beats.delete();
                    end
                end else begin
                    if (beats.size() > 0) m_abort = 1'b1;
                    beats.delete();
                    r  = ref_op(mode, int'(sel), longint'(imm), longint'(rs));
                    ld = 1'b1;
                end
            end
            if (ld) begin
                m_valid = 1'b1;
                m_data  = r;
                exp_q.push_back(r);
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  in_ready,  !m_valid || out_ready);
            chk("out_valid", out_valid, m_valid);
            chk("out_data",  out_data,  m_data);
            chk("seq_abort", seq_abort, m_abort);
            if (m_valid && out_ready && !rst) begin
                if (exp_q.size() == 0) chk("drain_empty", 1, 0);
                else chk("drain", out_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] m, input int s, input int im, input int r);
        bit done = 1'b0;
        mode = m;
        sel = SW'(s);
        imm = C'(im);
        rs = W'(r);
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] val);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk(name, out_data, val);
        chk({name, "_model"}, m_data, val);
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data",  out_data,  '0);
        chk("rst_seq_abort", seq_abort, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        step();

        send(3'd0, 0, 'b01011, 'b1111100000);
        expect_out("ins_lo", 10'b1111101011);
        send(3'd0, 1, 'b10101, 'b0000011111);
        expect_out("ins_hi", 10'b1010111111);
        send(3'd2, 0, 'b10010, 0);
        expect_out("sext", 10'b1111110010);
        send(3'd1, 0, 'b10010, 0);
        expect_out("zext", 10'b0000010010);
        send(3'd5, 0, 0, 'b1100110011);
        expect_out("reserved", 10'b1100110011);

        send(3'd3, 0, 'b00011, 0);
        @(negedge clk);
        chk("seq_beat1_valid", out_valid, 1'b0);
        step();
        send(3'd3, 0, 'b11100, 0);
        expect_out("seq_done", 10'b0001111100);

        // Backpressure: second request must wait until the first is taken.
        send(3'd1, 0, 'b00001, 0);
        out_ready = 1'b0;
        mode = 3'd1;
        imm = 5'b00010;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_hold", out_data, 10'b0000000001);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        expect_out("bp_second", 10'b0000000010);

        send(3'd3, 0, 'b00111, 0);
        send(3'd0, 0, 'b00000, 'h3FF);
        @(negedge clk);
        chk("abort_pulse", seq_abort, 1'b1);
        chk("abort_data", out_data, 10'b1111100000);
        step();
        @(negedge clk);
        chk("abort_pulse_end", seq_abort, 1'b0);
        step();
        send(3'd3, 0, 'b00001, 0);
        send(3'd3, 0, 'b00010, 0);
        expect_out("seq_after_abort", 10'b0000100010);

        send(3'd3, 0, 'b11111, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_data", out_data, '0);
        chk("midrst_abort", seq_abort, 1'b0);
        step();
        send(3'd3, 0, 'b00000, 0);
        send(3'd3, 0, 'b00001, 0);
        @(negedge clk);
        chk("midrst_no_abort", seq_abort, 1'b0);
        chk("midrst_seq", out_data, 10'b0000000001);
        step();

        // Random traffic, compared against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            mode      = ($urandom_range(0, 9) < 5) ? 3'd3 : 3'($urandom_range(0, 7));
            sel       = SW'($urandom_range(0, (1 << SW) - 1));
            imm       = C'($urandom);
            rs        = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
